// File: rtl/obstacle_gen.sv
// obstacle_gen: spawns, scrolls and retires up to ten rectangular obstacles
// for the side-scrolling game, feeding the game-logic stage.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (priority over everything)
//   tick        one-cycle frame pulse; motion and spawning happen only here
//   gamemode    00 initial (clear), 01 in-game, 10 paused, 11 ended
//   obstacle_x  slot i at [20*i +: 20] = {x_left[9:0], x_right[9:0]}
//   obstacle_y  slot i at [18*i +: 18] = {y_top[8:0], y_bottom[8:0]}
//   active      bit i set while slot i holds a live obstacle
module obstacle_gen #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned OBS_W    = 40,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned MIN_H    = 40,
    parameter int unsigned MIN_GAP  = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [1:0]   gamemode,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [9:0]   active
);

    localparam int          NumSlots = 10;
    localparam logic [1:0]  ModeInit = 2'b00;
    localparam logic [1:0]  ModeGame = 2'b01;
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam logic [9:0]  SpawnXl  = 10'(SCREEN_W);
    localparam logic [9:0]  SpawnXr  = 10'(SCREEN_W + OBS_W);
    localparam logic [9:0]  StepX    = 10'(SPEED);
    localparam logic [8:0]  FloorY   = 9'(SCREEN_H);
    localparam logic [8:0]  BaseH    = 9'(MIN_H);
    localparam logic [7:0]  BaseGap  = 8'(MIN_GAP);
    localparam logic [7:0]  GapMax   = 8'hFF;

    logic [9:0]          x_left_q   [NumSlots];
    logic [9:0]          x_left_d   [NumSlots];
    logic [9:0]          x_right_q  [NumSlots];
    logic [9:0]          x_right_d  [NumSlots];
    logic [8:0]          y_top_q    [NumSlots];
    logic [8:0]          y_top_d    [NumSlots];
    logic [8:0]          y_bottom_q [NumSlots];
    logic [8:0]          y_bottom_d [NumSlots];
    logic [NumSlots-1:0] active_q, active_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [7:0]          gap_target_q, gap_target_d;

    logic [NumSlots-1:0] free_mask;
    logic [3:0]          spawn_slot;
    logic                spawn_en;
    logic [8:0]          spawn_h;

    // Spawn decision uses the free mask before this tick's retires, so a slot
    // freed on a tick can only be reused on a later tick.
    always_comb begin
        free_mask  = ~active_q;
        spawn_slot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                spawn_slot = 4'(i);
            end
        end
        spawn_en = (gap_cnt_q >= gap_target_q) && (free_mask != '0);
        spawn_h  = BaseH + {2'b00, lfsr_q[6:0]};
    end

    always_comb begin
        // Galois LFSR, right shift, feedback from bit 0; free-running.
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
        x_left_d     = x_left_q;
        x_right_d    = x_right_q;
        y_top_d      = y_top_q;
        y_bottom_d   = y_bottom_q;
        active_d     = active_q;
        gap_cnt_d    = gap_cnt_q;
        gap_target_d = gap_target_q;

        if (gamemode == ModeInit) begin
            for (int i = 0; i < NumSlots; i++) begin
                x_left_d[i]   = '0;
                x_right_d[i]  = '0;
                y_top_d[i]    = '0;
                y_bottom_d[i] = '0;
            end
            active_d     = '0;
            gap_cnt_d    = '0;
            gap_target_d = BaseGap;
        end else if ((gamemode == ModeGame) && tick) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (active_q[i]) begin
                    if (x_right_q[i] <= StepX) begin
                        active_d[i]   = 1'b0;
                        x_left_d[i]   = '0;
                        x_right_d[i]  = '0;
                        y_top_d[i]    = '0;
                        y_bottom_d[i] = '0;
                    end else begin
                        // Left edge clamps at zero while the right edge keeps going.
                        x_left_d[i]  = (x_left_q[i] > StepX) ? (x_left_q[i] - StepX) : '0;
                        x_right_d[i] = x_right_q[i] - StepX;
                    end
                end
            end

            if (spawn_en) begin
                active_d[spawn_slot]  = 1'b1;
                x_left_d[spawn_slot]  = SpawnXl;
                x_right_d[spawn_slot] = SpawnXr;
                if (lfsr_q[15]) begin
                    y_top_d[spawn_slot]    = FloorY - spawn_h;
                    y_bottom_d[spawn_slot] = FloorY;
                end else begin
                    y_top_d[spawn_slot]    = '0;
                    y_bottom_d[spawn_slot] = spawn_h;
                end
                gap_cnt_d    = '0;
                gap_target_d = BaseGap + {2'b00, lfsr_q[13:8]};
            end else if (gap_cnt_q != GapMax) begin
                gap_cnt_d = gap_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumSlots; i++) begin
                x_left_q[i]   <= '0;
                x_right_q[i]  <= '0;
                y_top_q[i]    <= '0;
                y_bottom_q[i] <= '0;
            end
            active_q     <= '0;
            lfsr_q       <= SEED;
            gap_cnt_q    <= '0;
            gap_target_q <= BaseGap;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                x_left_q[i]   <= x_left_d[i];
                x_right_q[i]  <= x_right_d[i];
                y_top_q[i]    <= y_top_d[i];
                y_bottom_q[i] <= y_bottom_d[i];
            end
            active_q     <= active_d;
            lfsr_q       <= lfsr_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_target_q <= gap_target_d;
        end
    end

    // Outputs come straight from registers; inactive slots read as zero.
    always_comb begin
        obstacle_x = '0;
        obstacle_y = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (active_q[i]) begin
                obstacle_x[20*i +: 20] = {x_left_q[i], x_right_q[i]};
                obstacle_y[18*i +: 18] = {y_top_q[i], y_bottom_q[i]};
            end
        end
        active = active_q;
    end

endmodule

// File: tb/tb_obstacle_gen.sv
// Self-checking bench for obstacle_gen: a behavioural reference model feeds a
// scoreboard every cycle, a vector table covers reset / first spawn / scroll /
// pause, and hand-written sequences cover clamp+retire, clear, and a full
// buffer with a deferred spawn (second instance, slow scroll, zero min gap).
module tb_obstacle_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [1:0]   gamemode;
    logic [199:0] ox, ox2;
    logic [179:0] oy, oy2;
    logic [9:0]   act, act2;

    always #5 clk = ~clk;

    obstacle_gen dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .gamemode   (gamemode),
        .obstacle_x (ox),
        .obstacle_y (oy),
        .active     (act)
    );

    obstacle_gen #(
        .SCREEN_W (980),
        .OBS_W    (40),
        .SPEED    (1),
        .MIN_GAP  (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .gamemode   (gamemode),
        .obstacle_x (ox2),
        .obstacle_y (oy2),
        .active     (act2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state and the parameters of the instance it tracks.
    int          m_xl [10];
    int          m_xr [10];
    int          m_yt [10];
    int          m_yb [10];
    bit          m_act [10];
    int          m_cnt;
    int          m_tgt;
    logic [15:0] m_lfsr;
    int          p_sw, p_ow, p_sp, p_mg;
    int          sel;

    typedef struct {
        logic [199:0] x;
        logic [179:0] y;
        logic [9:0]   a;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       r;
        logic       t;
        logic [1:0] gm;
        logic [9:0] a;
        logic [19:0] x0;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [199:0] got, input logic [199:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [19:0] xp(input int l, input int r);
        return {10'(l), 10'(r)};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    task automatic m_clear(input int i);
        m_act[i] = 1'b0;
        m_xl[i]  = 0;
        m_xr[i]  = 0;
        m_yt[i]  = 0;
        m_yb[i]  = 0;
    endtask

    task automatic model(input logic r, input logic t, input logic [1:0] gm);
        int slot;
        int h;
        if (r || gm == 2'b00) begin
            for (int i = 0; i < 10; i++) m_clear(i);
            m_cnt = 0;
            m_tgt = p_mg;
        end else if (gm == 2'b01 && t) begin
            slot = -1;
            for (int i = 0; i < 10; i++) begin
                if (!m_act[i] && slot < 0) slot = i;
            end
            for (int i = 0; i < 10; i++) begin
                if (m_act[i]) begin
                    if (m_xr[i] <= p_sp) begin
                        m_clear(i);
                    end else begin
                        m_xl[i] = (m_xl[i] > p_sp) ? m_xl[i] - p_sp : 0;
                        m_xr[i] = m_xr[i] - p_sp;
                    end
                end
            end
            if (m_cnt >= m_tgt && slot >= 0) begin
                h = 40 + int'(m_lfsr[6:0]);
                m_act[slot] = 1'b1;
                m_xl[slot]  = p_sw;
                m_xr[slot]  = p_sw + p_ow;
                if (m_lfsr[15]) begin
                    m_yt[slot] = 480 - h;
                    m_yb[slot] = 480;
                end else begin
                    m_yt[slot] = 0;
                    m_yb[slot] = h;
                end
                m_cnt = 0;
                m_tgt = p_mg + int'(m_lfsr[13:8]);
            end else if (m_cnt < 255) begin
                m_cnt++;
            end
        end
        m_lfsr = r ? 16'hACE1 : lfsr_next(m_lfsr);
    endtask

    function automatic exp_t pack_model();
        exp_t e;
        e.x = '0;
        e.y = '0;
        e.a = '0;
        for (int i = 0; i < 10; i++) begin
            e.a[i] = m_act[i];
            if (m_act[i]) begin
                e.x[20*i +: 20] = {10'(m_xl[i]), 10'(m_xr[i])};
                e.y[18*i +: 18] = {9'(m_yt[i]), 9'(m_yb[i])};
            end
        end
        return e;
    endfunction

    // One clock cycle: drive, predict, push; then after the edge pop and compare.
    task automatic step(input logic r, input logic t, input logic [1:0] gm);
        exp_t e;
        rst      = r;
        tick     = t;
        gamemode = gm;
        model(r, t, gm);
        sb.push_back(pack_model());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (sel == 0) begin
            chk("sb_obstacle_x", ox, e.x);
            chk("sb_obstacle_y", 200'(oy), 200'(e.y));
            chk("sb_active", 200'(act), 200'(e.a));
        end else begin
            chk("sb2_obstacle_x", ox2, e.x);
            chk("sb2_obstacle_y", 200'(oy2), 200'(e.y));
            chk("sb2_active", 200'(act2), 200'(e.a));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        logic full;
        logic freed;
        int   yt, yb;

        rst = 1'b1;
        tick = 1'b0;
        gamemode = 2'b01;
        sel = 0;
        p_sw = 640; p_ow = 40; p_sp = 2; p_mg = 4;

        // Vector table: first spawn on tick 5, 10 scroll ticks, 5 paused ticks.
        for (int k = 0; k < 4; k++) tbl.push_back('{1'b0, 1'b1, 2'b01, 10'd0, 20'd0});
        tbl.push_back('{1'b0, 1'b1, 2'b01, 10'd1, xp(640, 680)});
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{1'b0, 1'b1, 2'b01, 10'd1, xp(640 - 2 * k, 680 - 2 * k)});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b0, 1'b1, 2'b10, 10'd1, xp(620, 660)});

        // Reset with gamemode in-game.
        step(1'b1, 1'b0, 2'b01);
        chk("reset_active", 200'(act), 200'(0));
        chk("reset_x", ox, 200'(0));
        chk("reset_y", 200'(oy), 200'(0));
        chk("reset_lfsr", 200'(dut.lfsr_q), 200'(16'hACE1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].gm);
            chk($sformatf("tbl%0d_active", i), 200'(act), 200'(tbl[i].a));
            chk($sformatf("tbl%0d_x0", i), 200'(ox[19:0]), 200'(tbl[i].x0));
            if (i == 4) begin
                yt = int'(oy[17:9]);
                yb = int'(oy[8:0]);
                ok = (yt == 0 && yb >= 40 && yb <= 167) ||
                     (yb == 480 && (480 - yt) >= 40 && (480 - yt) <= 167);
                chk("first_spawn_y_range", 200'(ok), 200'(1));
            end
        end

        // Ended mode ignores ticks too.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b11);
        chk("ended_x0", 200'(ox[19:0]), 200'(xp(620, 660)));

        // Clamp and retire of slot 0: 338 moves in total reach {0,4}.
        for (int k = 0; k < 327; k++) step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b01);
        chk("clamp_x0_0_4", 200'(ox[19:0]), 200'(xp(0, 4)));
        step(1'b0, 1'b1, 2'b01);
        chk("clamp_x0_0_2", 200'(ox[19:0]), 200'(xp(0, 2)));
        step(1'b0, 1'b1, 2'b01);
        chk("retire_active0", 200'(act[0]), 200'(0));
        chk("retire_x0", 200'(ox[19:0]), 200'(0));
        chk("retire_y0", 200'(oy[17:0]), 200'(0));

        // Idle cycles without tick change nothing (scoreboard checks).
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'b01);

        // Clear via gamemode 00, then first spawn on tick MIN_GAP+1.
        step(1'b0, 1'b0, 2'b00);
        chk("clear_active", 200'(act), 200'(0));
        chk("clear_x", ox, 200'(0));
        chk("clear_y", 200'(oy), 200'(0));
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 2'b01);
            chk($sformatf("clear_tick%0d_active", k), 200'(act), 200'(0));
        end
        step(1'b0, 1'b1, 2'b01);
        chk("clear_tick5_active", 200'(act), 200'(1));
        chk("clear_tick5_x0", 200'(ox[19:0]), 200'(xp(640, 680)));

        // Full buffer on the second instance.
        sel = 1;
        p_sw = 980; p_ow = 40; p_sp = 1; p_mg = 0;
        step(1'b1, 1'b1, 2'b01);
        chk("rst2_active", 200'(act2), 200'(0));
        full = 1'b0;
        for (int k = 0; k < 1000 && !full; k++) begin
            step(1'b0, 1'b1, 2'b01);
            if (act2 == 10'h3FF) full = 1'b1;
        end
        chk("fill_reached_full", 200'(full), 200'(1));
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 2'b01);
        chk("full_stays_full", 200'(act2), 200'(10'h3FF));
        chk("full_gap_cnt_counts", 200'(dut2.gap_cnt_q), 200'(8'(m_cnt)));

        freed = 1'b0;
        for (int k = 0; k < 1200 && !freed; k++) begin
            step(1'b0, 1'b1, 2'b01);
            if (act2[0] == 1'b0) freed = 1'b1;
        end
        chk("slot0_retired", 200'(freed), 200'(1));
        chk("deferred_active", 200'(act2), 200'(10'h3FE));
        chk("gap_cnt_saturated", 200'(dut2.gap_cnt_q), 200'(8'd255));
        step(1'b0, 1'b1, 2'b01);
        chk("deferred_spawn_active", 200'(act2), 200'(10'h3FF));
        chk("deferred_spawn_x0", 200'(ox2[19:0]), 200'(xp(980, 1020)));
        chk("deferred_gap_cnt_zero", 200'(dut2.gap_cnt_q), 200'(0));

        // Reset mid-run clears everything in one cycle.
        step(1'b1, 1'b1, 2'b01);
        chk("midrun_rst_active", 200'(act2), 200'(0));
        chk("midrun_rst_x", ox2, 200'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obstacle_gen.md
# obstacle_gen

Generates and scrolls up to 10 rectangular obstacles for the side-scrolling game. It sits directly upstream of the game-logic stage and drives the packed `obstacle_x` / `obstacle_y` buses that stage consumes. It follows the same `gamemode` encoding: it spawns and moves obstacles only while in-game, freezes them while paused or ended, and clears them in the initial state.

## Interface
- `SCREEN_W`, 640: x at which new obstacles appear (left edge).
- `SCREEN_H`, 480: bottom y bound.
- `OBS_W`, 40: obstacle width in pixels.
- `SPEED`, 2: pixels moved left per tick.
- `MIN_H`, 40: minimum obstacle height.
- `MIN_GAP`, 4: minimum ticks between spawns.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `tick` in 1: one-cycle frame pulse; all motion and spawning happen only on cycles where `tick`=1.
- `gamemode` in 2: 00 = initial, 01 = in-game, 10 = paused, 11 = ended.
- `obstacle_x` out 200: slot i at bits `[20*i +: 20]`, packed as `{x_left[9:0], x_right[9:0]}`.
- `obstacle_y` out 180: slot i at bits `[18*i +: 18]`, packed as `{y_top[8:0], y_bottom[8:0]}`.
- `active` out 10: bit i set when slot i holds a live obstacle.

## Operation
- **Storage and outputs**
  - Per-slot registers hold x_left, x_right, y_top, y_bottom and active.
  - An inactive slot drives all-zero x and y fields. The zero width lets downstream treat it as absent.
- **LFSR**
  - 16-bit Galois LFSR, mask 16'hB400, shifting right with feedback from bit 0.
  - Advances every clk cycle when not in reset, regardless of `gamemode`.
- **Gap control**
  - 8-bit `gap_cnt` counts ticks since the last spawn. 6+-bit `gap_target` sets the required spacing.
  - Reset values: `gap_cnt`=0, `gap_target`=`MIN_GAP`.
- **`gamemode`=00:** synchronous clear, identical to reset except the LFSR keeps running.
- **`gamemode`=10 or 11:** all state holds; `tick` is ignored.
- **`gamemode`=01 and `tick`=1** — perform in one cycle:
  - **Move:** every active slot gets x_left ← sat0(x_left − `SPEED`) and x_right ← x_right − `SPEED`.
  - **Retire:** an active slot with x_right ≤ `SPEED` is cleared (active=0, fields zero) instead of moved.
  - **Spawn:**
    - Condition: `gap_cnt` ≥ `gap_target` and the free mask, taken before this tick's retires, is nonzero.
    - Target slot: the lowest-index free slot.
    - x = {`SCREEN_W`, `SCREEN_W`+`OBS_W`}.
    - h = `MIN_H` + lfsr[6:0].
    - If lfsr[15]=0, the obstacle hangs from the top: y = {0, h}.
    - Otherwise it stands on the floor: y = {`SCREEN_H`−h, `SCREEN_H`}.
    - Then `gap_cnt` ← 0 and `gap_target` ← `MIN_GAP` + lfsr[13:8] (6 bits).
  - **No spawn:**
    - `gap_cnt` increments, saturating at 255.
    - If the gap has expired but every slot is full, the spawn is deferred. It fires on the first tick with a free slot.
- A slot retired on a tick is reusable only from the next tick onward.
- **Widths:** all x arithmetic is 10-bit unsigned and y arithmetic is 9-bit unsigned. h ≤ 167, so no overflow.

## Timing
- Every output is registered.
- A change caused by a tick (or a `gamemode` / `rst` edge) is visible on the outputs on the clk edge following the cycle in which it was sampled. Latency is 1 cycle.
- Reset values: `obstacle_x`=0, `obstacle_y`=0, `active`=0, LFSR=`SEED`.
- `rst` has priority over `gamemode` and `tick`. `rst` mid-run clears everything in one cycle.
- `gamemode` leaving 01 on the same cycle as `tick`: the new mode is what is sampled, so that tick is ignored.
- Consecutive `tick` cycles are legal; each one is processed fully.

## Test plan
1. **Reset:** `rst`=1 for 1 cycle with `gamemode`=01 → `active`=0, `obstacle_x`=0, `obstacle_y`=0; the LFSR reads 16'hACE1 on the next cycle.
2. **First spawn:** `gamemode`=01, five ticks → no spawn on ticks 1–4. After tick 5: `active`=10'b1, slot 0 x = {640, 680}, slot 0 y is either {0, h} or {480−h, 480} with 40 ≤ h ≤ 167.
3. **Scroll and pause:** after the first spawn, 10 more ticks → slot 0 x = {620, 660}. Then `gamemode`=10 and 5 ticks → x still {620, 660}.
4. **Retire and clamp:** drive an obstacle to x_left=0, x_right=4. Next tick → {0, 2}. The following tick → slot cleared: `active`[0]=0, fields zero.
5. **Full buffer:** use `SPEED`=0 and `MIN_GAP`=0 to fill all 10 slots. Further ticks → no change, and `gap_cnt` keeps counting. Free one slot via `gamemode` behaviour or a test override → the spawn lands in that slot on the first subsequent tick.
6. **Clear:** any active set, then `gamemode`=00 for 1 cycle → all outputs zero. Return to 01 → the first spawn occurs on tick `MIN_GAP`+1.
